// File: rtl/beta_tlb_walker.sv
// beta_tlb_walker: two-level page-table walker producing Beta MMU TLB fills or faults,
// with a one-entry L1 PTE cache so misses in the same 4 MB region skip the L1 read.
module beta_tlb_walker #(
    parameter int CTX_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MissValid,
    output logic               MissReady,
    input  logic [CTX_W-1:0]   MissContext,
    input  logic [31:0]        MissAddress,
    input  logic [31:0]        pTblePtr,
    input  logic               Flush,
    output logic [31:0]        MemAddress,
    output logic               MemReadEnable,
    input  logic [31:0]        MemDataIn,
    input  logic               MemDataReady,
    output logic               FillValid,
    output logic [CTX_W+19:0]  FillTag,
    output logic [19:0]        FillPPN,
    output logic               Fault,
    output logic [1:0]         FaultCode
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, FILL, FAULT} state_t;
    state_t state, state_n;
    logic [CTX_W-1:0] ctx, l1_ctx;
    logic [19:0] vpn, base, l1_base, l1_pte;
    logic [9:0] l1_vpn1;
    logic [15:0] cnt;
    logic [1:0] code_n;
    logic l1_v, abort, hit, waiting, timed_out;
    logic unused_bits;
    assign unused_bits = ^{MemDataIn[11:1], MissAddress[11:0], pTblePtr[11:0]};
    assign MissReady = state == IDLE;
    assign waiting = state == L1_WAIT || state == L2_WAIT;
    assign MemReadEnable = waiting;
    assign FillValid = state == FILL;
    assign Fault = state == FAULT;
    // A flush on the accept edge already counts as invalidating the cache.
    assign hit = l1_v && !Flush && l1_ctx == MissContext && l1_base == pTblePtr[31:12]
                 && l1_vpn1 == MissAddress[31:22];
    assign timed_out = waiting && !MemDataReady && cnt >= 16'(TIMEOUT - 1);
    always_comb begin
        state_n = state;
        code_n = 2'b00;
        case (state)
            IDLE: if (MissValid) state_n = hit ? L2_REQ : L1_REQ;
            L1_REQ: state_n = Flush ? IDLE : L1_WAIT;
            L2_REQ: state_n = Flush ? IDLE : L2_WAIT;
            L1_WAIT, L2_WAIT: if (MemDataReady || timed_out) begin
                code_n = timed_out ? 2'b11 : (state == L1_WAIT ? 2'b01 : 2'b10);
                state_n = (abort || Flush) ? IDLE :
                          (timed_out || !MemDataIn[0]) ? FAULT :
                          (state == L1_WAIT ? L2_REQ : FILL);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctx <= '0;
            vpn <= '0;
            base <= '0;
            cnt <= '0;
            abort <= 1'b0;
            l1_v <= 1'b0;
            l1_ctx <= '0;
            l1_base <= '0;
            l1_vpn1 <= '0;
            l1_pte <= '0;
            MemAddress <= '0;
            FillTag <= '0;
            FillPPN <= '0;
            FaultCode <= 2'b00;
        end else begin
            state <= state_n;
            cnt <= waiting ? cnt + 16'd1 : 16'd0;
            if (state == IDLE && MissValid) begin
                ctx <= MissContext;
                vpn <= MissAddress[31:12];
                base <= pTblePtr[31:12];
                FaultCode <= 2'b00;
                abort <= 1'b0;
            end else if (waiting && Flush) begin
                abort <= 1'b1;
            end
            if (state == L1_REQ) MemAddress <= {base, vpn[19:10], 2'b00};
            if (state == L2_REQ) MemAddress <= {l1_pte, vpn[9:0], 2'b00};
            if (state == L1_WAIT && state_n == L2_REQ) begin
                l1_v <= 1'b1;
                l1_ctx <= ctx;
                l1_base <= base;
                l1_vpn1 <= vpn[19:10];
                l1_pte <= MemDataIn[31:12];
            end
            if (Flush) l1_v <= 1'b0;
            if (state == L2_WAIT && state_n == FILL) begin
                FillPPN <= MemDataIn[31:12];
                FillTag <= {ctx, vpn};
            end
            if (state_n == FAULT) FaultCode <= code_n;
        end
    end
endmodule

// File: tb/tb_beta_tlb_walker.sv
// tb_beta_tlb_walker: directed walks against a memory model; a scoreboard of expected
// PTE reads and fill/fault responses is drained by an independent monitor.
module tb_beta_tlb_walker;
    logic clk, rst, MissValid, MissReady, Flush, MemReadEnable, MemDataReady, FillValid, Fault;
    logic [15:0] MissContext;
    logic [31:0] MissAddress, pTblePtr, MemAddress, MemDataIn;
    logic [35:0] FillTag;
    logic [19:0] FillPPN;
    logic [1:0] FaultCode;
    typedef struct {
        bit is_fill;
        logic [35:0] tag;
        logic [19:0] ppn;
        logic [1:0] code;
        int lat;
    } rsp_t;
    rsp_t exp_rsp[$];
    logic [31:0] exp_rd[$];
    logic [31:0] mem[logic [31:0]];
    int pass = 0, total = 0, cyc = 0, acc_cyc = 0, mem_delay = 0;
    bit never_ready = 0;

    beta_tlb_walker #(.CTX_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .MissValid(MissValid), .MissReady(MissReady),
        .MissContext(MissContext), .MissAddress(MissAddress), .pTblePtr(pTblePtr),
        .Flush(Flush), .MemAddress(MemAddress), .MemReadEnable(MemReadEnable),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady), .FillValid(FillValid),
        .FillTag(FillTag), .FillPPN(FillPPN), .Fault(Fault), .FaultCode(FaultCode)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        total++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory responder: answers mem_delay cycles after the enable is first seen.
    initial begin
        int w = 0;
        MemDataReady = 0;
        MemDataIn = 0;
        forever begin
            @(negedge clk);
            MemDataReady = 0;
            if (MemReadEnable && !never_ready) begin
                if (w >= mem_delay) begin
                    MemDataReady = 1;
                    MemDataIn = rd(MemAddress);
                    w = 0;
                end else w++;
            end else w = 0;
        end
    end

    // Monitor: checks each new read address and each fill/fault pulse against the queues.
    initial begin
        logic prev_en = 0;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (MemReadEnable && !prev_en) begin
                if (exp_rd.size() == 0) note_fail("spurious_read", MemAddress);
                else chk("read_addr", MemAddress, exp_rd.pop_front());
            end
            prev_en = MemReadEnable;
            if (FillValid) begin
                if (exp_rsp.size() == 0) note_fail("spurious_fill", FillTag);
                else begin
                    e = exp_rsp.pop_front();
                    if (!e.is_fill) note_fail("fill_instead_of_fault", FillTag);
                    else begin
                        chk("fill_tag", FillTag, e.tag);
                        chk("fill_ppn", FillPPN, e.ppn);
                        if (e.lat != 0) chk("fill_latency", cyc - acc_cyc, e.lat);
                    end
                end
            end
            if (Fault) begin
                if (exp_rsp.size() == 0) note_fail("spurious_fault", FaultCode);
                else begin
                    e = exp_rsp.pop_front();
                    if (e.is_fill) note_fail("fault_instead_of_fill", FaultCode);
                    else chk("fault_code", FaultCode, e.code);
                end
            end
        end
    end

    task automatic exp_fill(input logic [15:0] c, input logic [19:0] v, input logic [19:0] p, input int lat);
        rsp_t e;
        e.is_fill = 1; e.tag = {c, v}; e.ppn = p; e.code = 0; e.lat = lat;
        exp_rsp.push_back(e);
    endtask

    task automatic exp_fault(input logic [1:0] code);
        rsp_t e;
        e.is_fill = 0; e.tag = 0; e.ppn = 0; e.code = code; e.lat = 0;
        exp_rsp.push_back(e);
    endtask

    task automatic issue(input logic [15:0] c, input logic [31:0] va);
        int n = 0;
        while (!MissReady && n < 50) begin @(negedge clk); n++; end
        if (!MissReady) note_fail("ready_timeout", MissReady);
        MissValid = 1; MissContext = c; MissAddress = va; acc_cyc = cyc;
        @(negedge clk);
        MissValid = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 100 && !(exp_rsp.size() == 0 && exp_rd.size() == 0 && MissReady)) begin
            @(negedge clk); #1; n++;
        end
        chk({name, "_rsp_left"}, exp_rsp.size(), 0);
        chk({name, "_rd_left"}, exp_rd.size(), 0);
    endtask

    task automatic wait_sig(input string name, input bit which);
        int n = 0;
        while (n < 60 && !(which ? Fault : MemReadEnable)) begin @(negedge clk); #1; n++; end
        if (!(which ? Fault : MemReadEnable)) note_fail({name, "_wait_timeout"}, 0);
    endtask

    initial begin
        rst = 0; MissValid = 0; Flush = 0; MissContext = 0; MissAddress = 0;
        pTblePtr = 32'h0001_0000;
        mem[32'h0001_0004] = 32'h0002_0001;
        mem[32'h0002_000C] = 32'h7654_3001;
        mem[32'h0002_0014] = 32'h1234_5001;
        mem[32'h0001_0008] = 32'h0002_0000;
        mem[32'h0001_000C] = 32'h0003_0001;
        mem[32'h0001_0014] = 32'h0004_0001;
        mem[32'h0004_0000] = 32'h0ABC_D001;
        repeat (2) @(negedge clk);
        chk("rst_ready", MissReady, 1);
        chk("rst_en", MemReadEnable, 0);
        chk("rst_addr", MemAddress, 0);
        chk("rst_fillvalid", FillValid, 0);
        chk("rst_filltag", FillTag, 0);
        chk("rst_fillppn", FillPPN, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_faultcode", FaultCode, 0);
        rst = 1;
        @(negedge clk);
        // cache miss, full two-level walk
        exp_rd.push_back(32'h0001_0004); exp_rd.push_back(32'h0002_000C);
        exp_fill(16'd5, 20'h00403, 20'h76543, 5);
        issue(16'd5, 32'h0040_3ABC);
        drain("t1");
        // same 4 MB region: L1 cache hit, only the L2 read
        exp_rd.push_back(32'h0002_0014);
        exp_fill(16'd5, 20'h00405, 20'h12345, 3);
        issue(16'd5, 32'h0040_5000);
        drain("t2");
        // invalid L1 PTE
        exp_rd.push_back(32'h0001_0008);
        exp_fault(2'b01);
        issue(16'd5, 32'h0080_0000);
        wait_sig("t3", 1);
        @(negedge clk); #1;
        chk("t3_ready_after_fault", MissReady, 1);
        chk("t3_fault_one_cycle", Fault, 0);
        drain("t3");
        // invalid L2 PTE
        exp_rd.push_back(32'h0001_000C); exp_rd.push_back(32'h0003_0000);
        exp_fault(2'b10);
        issue(16'd5, 32'h00C0_0000);
        drain("t3b");
        // memory never answers: bus timeout
        never_ready = 1;
        exp_rd.push_back(32'h0001_0010);
        exp_fault(2'b11);
        issue(16'd5, 32'h0100_0000);
        wait_sig("t4", 1);
        chk("t4_en_dropped", MemReadEnable, 0);
        never_ready = 0;
        drain("t4");
        // flush during L1_WAIT: silent abort, cache invalid afterwards
        mem_delay = 3;
        exp_rd.push_back(32'h0001_0014);
        issue(16'd5, 32'h0140_0000);
        wait_sig("t5", 0);
        Flush = 1;
        @(negedge clk);
        Flush = 0;
        repeat (10) @(negedge clk);
        #1;
        chk("t5_ready", MissReady, 1);
        chk("t5_rd_left", exp_rd.size(), 0);
        mem_delay = 0;
        exp_rd.push_back(32'h0001_0014); exp_rd.push_back(32'h0004_0000);
        exp_fill(16'd5, 20'h01400, 20'h0ABCD, 5);
        issue(16'd5, 32'h0140_0000);
        drain("t5b");
        // reset in L2_WAIT (cache hit walk): outputs drop at once, no fill later
        never_ready = 1;
        exp_rd.push_back(32'h0004_0004);
        issue(16'd5, 32'h0140_1000);
        wait_sig("t6", 0);
        rst = 0;
        #1;
        chk("t6_en_async", MemReadEnable, 0);
        chk("t6_ready_async", MissReady, 1);
        chk("t6_addr_async", MemAddress, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        never_ready = 0;
        repeat (10) @(negedge clk);
        #1;
        chk("t6_ready_after", MissReady, 1);
        chk("t6_rd_left", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
